// File: rtl/task_icd_pkg.sv
// task_icd_pkg: shared output-command word layout for the command task handler and its strobe driver
package task_icd_pkg;
  localparam logic [3:0] OUT_CMD_ID = 4'b0001;
  localparam int CMD_ID_MSB = 31;
  localparam int CMD_ID_LSB = 28;
  localparam int CMD_RSV_MSB = 27;
  localparam int CMD_RSV_LSB = 5;
  localparam int CMD_IDX_MSB = 4;
  localparam int CMD_IDX_LSB = 0;
  function automatic logic cmd_is_out(input logic [31:0] w);
    return w[CMD_ID_MSB:CMD_ID_LSB] == OUT_CMD_ID && w[CMD_RSV_MSB:CMD_RSV_LSB] == '0;
  endfunction
endpackage

// File: rtl/out_strobe_drv.sv
// out_strobe_drv: decodes OUT command words into a fixed-width one-hot strobe followed by a hold-off gap
module out_strobe_drv
  import task_icd_pkg::*;
#(
  parameter int PULSE_CYCLES = 16,
  parameter int HOLDOFF_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        asi_cmd_valid,
  output logic        asi_cmd_ready,
  input  logic [31:0] asi_cmd_data,
  output logic [31:0] strobe_out,
  output logic        busy,
  output logic        bad_cmd_pulse,
  output logic [15:0] bad_cmd_cnt
);
  typedef enum logic [1:0] {IDLE, PULSE, HOLDOFF} state_t;
  localparam logic [15:0] P_M1 = 16'(PULSE_CYCLES - 1);
  localparam logic [15:0] H_M1 = 16'(HOLDOFF_CYCLES - 1);
  state_t state, state_n;
  logic [15:0] cnt, cnt_n, bad_cnt_n;
  logic [31:0] strobe_n;
  logic bad_n, acc;
  assign acc = asi_cmd_valid & asi_cmd_ready;
  // one down-counter times both the pulse and the hold-off phase
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    strobe_n = strobe_out;
    bad_n = 1'b0;
    bad_cnt_n = bad_cmd_cnt;
    case (state)
      IDLE: if (acc) begin
        if (cmd_is_out(asi_cmd_data)) begin
          state_n = PULSE;
          cnt_n = P_M1;
          strobe_n = 32'd1 << asi_cmd_data[CMD_IDX_MSB:CMD_IDX_LSB];
        end else begin
          bad_n = 1'b1;
          bad_cnt_n = bad_cmd_cnt == 16'hFFFF ? bad_cmd_cnt : bad_cmd_cnt + 16'd1;
        end
      end
      PULSE: if (cnt == '0) begin
        strobe_n = '0;
        state_n = HOLDOFF_CYCLES == 0 ? IDLE : HOLDOFF;
        cnt_n = H_M1;
      end else cnt_n = cnt - 16'd1;
      HOLDOFF: begin
        state_n = cnt == '0 ? IDLE : HOLDOFF;
        cnt_n = cnt - 16'd1;
      end
      default: begin
        state_n = IDLE;
        strobe_n = '0;
        cnt_n = '0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      strobe_out <= '0;
      asi_cmd_ready <= 1'b0;
      busy <= 1'b0;
      bad_cmd_pulse <= 1'b0;
      bad_cmd_cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      strobe_out <= strobe_n;
      asi_cmd_ready <= state_n == IDLE;
      busy <= state_n != IDLE;
      bad_cmd_pulse <= bad_n;
      bad_cmd_cnt <= bad_cnt_n;
    end
endmodule

// File: tb/tb_out_strobe_drv.sv
// tb_out_strobe_drv: table-driven and scoreboarded bench for out_strobe_drv
module tb_out_strobe_drv;
  localparam int P = 16;
  localparam int H = 4;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic v = 0, r, b, bp;
  logic [31:0] d = 0, s;
  logic [15:0] bc;
  logic v2 = 0, r2, b2, bp2;
  logic [31:0] d2 = 0, s2;
  logic [15:0] bc2;
  out_strobe_drv #(.PULSE_CYCLES(P), .HOLDOFF_CYCLES(H)) dut (
    .clk(clk), .rst(rst), .asi_cmd_valid(v), .asi_cmd_ready(r), .asi_cmd_data(d),
    .strobe_out(s), .busy(b), .bad_cmd_pulse(bp), .bad_cmd_cnt(bc));
  out_strobe_drv #(.PULSE_CYCLES(1), .HOLDOFF_CYCLES(0)) dut2 (
    .clk(clk), .rst(rst), .asi_cmd_valid(v2), .asi_cmd_ready(r2), .asi_cmd_data(d2),
    .strobe_out(s2), .busy(b2), .bad_cmd_pulse(bp2), .bad_cmd_cnt(bc2));
  typedef struct {logic [31:0] data; logic good; logic [31:0] strobe;} vec_t;
  typedef struct {logic [31:0] strobe; logic bad; logic [15:0] cnt;} exp_t;
  exp_t sbq[$];
  vec_t tbl[8];
  int n_chk = 0, n_fail = 0;
  logic [15:0] exp_cnt = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic send(input logic [31:0] w, input logic good, input logic [31:0] strb);
    int t = 0;
    exp_t e;
    v = 1;
    d = w;
    while (!r && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("accept_wait", r, 1);
    if (r) begin
      if (!good) exp_cnt = exp_cnt == 16'hFFFF ? exp_cnt : exp_cnt + 16'd1;
      e.strobe = good ? strb : 32'd0;
      e.bad = !good;
      e.cnt = exp_cnt;
      sbq.push_back(e);
    end
    @(negedge clk);
    v = 0;
  endtask
  task automatic pop_chk();
    exp_t e;
    if (sbq.size() == 0) return;
    e = sbq.pop_front();
    chk("strobe_t1", s, e.strobe);
    chk("bad_pulse_t1", bp, e.bad);
    chk("bad_cnt_t1", bc, e.cnt);
    chk("ready_t1", r, e.bad);
  endtask
  task automatic shape(input logic [31:0] strb);
    for (int k = 1; k <= P + H + 1; k++) begin
      if (k > 1) @(negedge clk);
      chk("shape_strobe", s, k <= P ? strb : 32'd0);
      chk("shape_ready", r, k == P + H + 1);
      chk("shape_busy", b, k <= P + H);
    end
  endtask
  initial begin
    int miss;
    tbl[0] = '{32'h1000_0005, 1, 32'h0000_0020};
    tbl[1] = '{32'h2000_0003, 0, 32'h0};
    tbl[2] = '{32'h1000_0100, 0, 32'h0};
    tbl[3] = '{32'h1000_0000, 1, 32'h0000_0001};
    tbl[4] = '{32'h1000_001F, 1, 32'h8000_0000};
    tbl[5] = '{32'hF000_0001, 0, 32'h0};
    tbl[6] = '{32'h0000_0004, 0, 32'h0};
    tbl[7] = '{32'h1800_0002, 0, 32'h0};
    @(negedge clk);
    chk("rst_ready", r, 0);
    chk("rst_strobe", s, 0);
    chk("rst_busy", b, 0);
    chk("rst_cnt", bc, 0);
    rst = 0;
    @(negedge clk);
    chk("rel_ready", r, 1);
    chk("rel_ready2", r2, 1);
    chk("rel_strobe", s, 0);
    chk("rel_cnt", bc, 0);
    foreach (tbl[i]) begin
      send(tbl[i].data, tbl[i].good, tbl[i].strobe);
      pop_chk();
      if (tbl[i].good) shape(tbl[i].strobe);
      else begin
        @(negedge clk);
        chk("bad_pulse_t2", bp, 0);
        chk("bad_ready_t2", r, 1);
        chk("bad_strobe_t2", s, 0);
      end
    end
    v = 1;
    d = 32'h1000_001F;
    for (int k = 1; k <= 2 * (P + H + 1); k++) begin
      @(negedge clk);
      if (k == P + H + 2) v = 0;
      chk("b2b_strobe31", s, (k <= P || (k > P + H + 1 && k <= 2 * P + H + 1)) ? 32'h8000_0000 : 32'd0);
      chk("b2b_ready", r, k == P + H + 1 || k == 2 * (P + H + 1));
    end
    v = 1;
    d = 32'h2000_0003;
    miss = 0;
    for (int k = 0; k < 70000; k++) begin
      if (!r) miss++;
      @(negedge clk);
    end
    v = 0;
    exp_cnt = 16'hFFFF;
    chk("sat_ready_miss", miss, 0);
    chk("sat_cnt", bc, exp_cnt);
    chk("sat_pulse", bp, 1);
    chk("sat_strobe", s, 0);
    @(negedge clk);
    chk("sat_pulse_end", bp, 0);
    send(32'h1000_0003, 1, 32'h0000_0008);
    pop_chk();
    repeat (4) @(negedge clk);
    chk("mid_strobe_before", s, 32'h0000_0008);
    #2 rst = 1;
    #1;
    chk("mid_rst_strobe", s, 0);
    chk("mid_rst_busy", b, 0);
    chk("mid_rst_ready", r, 0);
    chk("mid_rst_cnt", bc, 0);
    exp_cnt = 0;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("mid_rel_ready", r, 1);
    send(32'h1000_0009, 1, 32'h0000_0200);
    pop_chk();
    shape(32'h0000_0200);
    v2 = 1;
    d2 = 32'h1000_0007;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 8) v2 = 0;
      chk("p1_strobe", s2, k % 2 == 1 ? 32'h0000_0080 : 32'd0);
      chk("p1_ready", r2, k % 2 == 0);
    end
    @(negedge clk);
    chk("p1_idle_strobe", s2, 0);
    chk("p1_idle_ready", r2, 1);
    chk("p1_bad_cnt", bc2, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
